// File: rtl/rv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
package rv_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_WB_ALU  = 4'd4,
        S_EX_ADDR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BR      = 4'd9,
        S_JMP     = 4'd10,
        S_EX_JR   = 4'd11,
        S_JR      = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    // Which ALU operation family the current state asks for
    typedef enum logic [1:0] {
        AC_ADD = 2'd0,
        AC_R   = 2'd1,
        AC_I   = 2'd2,
        AC_BR  = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic       PC_PLUS4 = 1'b0;
    localparam logic       PC_ALU   = 1'b1;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] IMM_J = 2'd0;
    localparam logic [1:0] IMM_B = 2'd1;
    localparam logic [1:0] IMM_S = 2'd2;
    localparam logic [1:0] IMM_L = 2'd3;

    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_ZERO = 2'd1;
    localparam logic [1:0] ALUA_PCC  = 2'd2;

    localparam logic       ALUB_REG = 1'b0;
    localparam logic       ALUB_IMM = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic       DATAW_REGB   = 1'b0;
    localparam logic       DATAW_ALUOUT = 1'b1;
    localparam logic       ADDR_ALUOUT1 = 1'b0;
    localparam logic       ADDR_ALUOUT2 = 1'b1;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation select from the requested operation family and instruction fields.
import rv_pkg::*;

module rv_alu_dec (
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [3:0] alusel
);

    // Branches compare with SUB for eq/ne, SLT/SLTU for the ordered forms
    always_comb begin
        alusel = ALU_ADD;
        case (alu_class)
            AC_R:    alusel = {f7b5, funct3};
            AC_I:    alusel = {1'b0, funct3};
            AC_BR: begin
                if (!funct3[2])     alusel = ALU_SUB;
                else if (!funct3[1]) alusel = ALU_SLT;
                else                alusel = ALU_SLTU;
            end
            default: alusel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM driving the datapath selects and enables.
//
// state     | meaning
// ----------+---------------------------------------------------
// FETCH     | load IR, capture PCC, PC <= PC+4
// DECODE    | A/B load rs1/rs2; ALUOUT <= PCC + imm (branch/jump target)
// EX_R      | register-register ALU op
// EX_I      | register-immediate ALU op
// WB_ALU    | write ALUOUT to rd
// EX_ADDR   | compute load/store address
// MEM_RD    | capture load data into MDR
// WB_MEM    | write MDR to rd
// MEM_WR    | store B to memory
// BR        | compare; on taken, PC <= target held in ALUOUT
// JMP       | JAL: rd <= PC (already PC+4), PC <= target
// EX_JR     | JALR: ALUOUT <= rs1 + imm
// JR        | JALR: rd <= PC, PC <= target
// HALT      | unsupported instruction, wait for reset
import rv_pkg::*;

module rv_ctl #(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic [1:0]         asel,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               datawsel,
    output logic               addrsel,
    output logic               dmem_wen,
    output logic               instr_done,
    output logic               illegal
);

    state_t     state;
    state_t     state_nx;
    alu_class_t alu_class;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    assign unused_instr = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    // Store data always comes from B and the address from ALUOUT in this datapath
    assign datawsel = DATAW_REGB;
    assign addrsel  = ADDR_ALUOUT1;

    rv_alu_dec u_alu_dec (
        .alu_class (alu_class),
        .funct3    (funct3),
        .f7b5      (f7b5),
        .alusel    (alusel)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Next state and outputs; outputs are held at defaults while rst is high
    // so that FETCH does not strobe IR/PC during reset
    always_comb begin
        state_nx   = state;
        pcsourse   = PC_PLUS4;
        pcwrite    = 1'b0;
        pccen      = 1'b0;
        irwrite    = 1'b0;
        wbsel      = WB_ALUOUT;
        regwen     = 1'b0;
        immsel     = IMM_L;
        asel       = ALUA_REG;
        bsel       = ALUB_REG;
        alu_class  = AC_ADD;
        mdrwrite   = 1'b0;
        dmem_wen   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    irwrite  = 1'b1;
                    pccen    = 1'b1;
                    pcwrite  = 1'b1;
                    state_nx = S_DECODE;
                end
                S_DECODE: begin
                    asel   = ALUA_PCC;
                    bsel   = ALUB_IMM;
                    immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
                    case (opcode)
                        OP_OP:     state_nx = S_EX_R;
                        OP_OPIMM:  state_nx = (funct3 == 3'b101 && f7b5) ? S_HALT : S_EX_I;
                        OP_LOAD:   state_nx = S_EX_ADDR;
                        OP_STORE:  state_nx = S_EX_ADDR;
                        OP_BRANCH: state_nx = (funct3[2:1] == 2'b01) ? S_HALT : S_BR;
                        OP_JAL:    state_nx = S_JMP;
                        OP_JALR:   state_nx = S_EX_JR;
                        default:   state_nx = S_HALT;
                    endcase
                end
                S_EX_R: begin
                    alu_class = AC_R;
                    state_nx  = S_WB_ALU;
                end
                S_EX_I: begin
                    bsel      = ALUB_IMM;
                    alu_class = AC_I;
                    state_nx  = S_WB_ALU;
                end
                S_WB_ALU: begin
                    regwen     = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_EX_ADDR: begin
                    bsel     = ALUB_IMM;
                    immsel   = (opcode == OP_STORE) ? IMM_S : IMM_L;
                    state_nx = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bsel     = ALUB_IMM;
                    mdrwrite = 1'b1;
                    state_nx = S_WB_MEM;
                end
                S_WB_MEM: begin
                    wbsel      = WB_MDR;
                    regwen     = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_MEM_WR: begin
                    dmem_wen   = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_BR: begin
                    alu_class  = AC_BR;
                    pcsourse   = PC_ALU;
                    // SUB/SLT yield zero=1 for eq / not-less; funct3[0]^funct3[2] inverts the sense
                    pcwrite    = zero ^ (funct3[0] ^ funct3[2]);
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_JMP, S_JR: begin
                    pcwrite    = 1'b1;
                    pcsourse   = PC_ALU;
                    regwen     = 1'b1;
                    wbsel      = WB_PC;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_EX_JR: begin
                    bsel     = ALUB_IMM;
                    state_nx = S_JR;
                end
                S_HALT: begin
                    illegal  = 1'b1;
                    state_nx = S_HALT;
                end
                default: state_nx = S_HALT;
            endcase
        end
    end

endmodule

// File: doc/rv_ctl.md
Name: rv_ctl

Overview:
- Multicycle control FSM for the simple RISC-V core; the control-side end of the datapath's control interface.
- Consumes `instr` (IR contents) and `zero` from the datapath.
- Drives every datapath select/enable, plus the data-memory write strobe and status flags.
- Supported: R-type ALU ops, OP-IMM except SRAI, LW, SW, all six branches, JAL, JALR. Anything else halts the core.

Parameters:
- DPWIDTH, 32, instruction/data width (`instr` port width).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr  in  DPWIDTH  current IR from datapath
- zero  in  1  ALU result == 0 (combinational, current cycle)
- pcsourse  out  1  PC_PLUS4=0, PC_ALU=1
- pcwrite  out  1  PC load enable
- pccen  out  1  PCC capture enable
- irwrite  out  1  IR load enable
- wbsel  out  2  WB_MDR=0, WB_ALUOUT=1, WB_PC=2
- regwen  out  1  register-file write enable
- immsel  out  2  IMM_J=0, IMM_B=1, IMM_S=2, IMM_L=3
- asel  out  2  ALUA_REG=0, ALUA_ZERO=1, ALUA_PCC=2
- bsel  out  1  ALUB_REG=0, ALUB_IMM=1
- alusel  out  4  {f7b5,funct3}: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101
- mdrwrite  out  1  MDR capture enable
- datawsel  out  1  DATAW_REGB=0, DATAW_ALUOUT=1; constant 0
- addrsel  out  1  ADDR_ALUOUT1=0, ADDR_ALUOUT2=1; constant 0
- dmem_wen  out  1  data-memory write strobe
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  sticky; set on entering HALT

Behaviour:
- Datapath facts this FSM relies on:
  - A/B and ALUOUT register every cycle.
  - PC update and RF write happen at the same edge.
  - `zero` reflects the current-cycle ALU operands.
- Default every cycle: all enables 0; wbsel=WB_ALUOUT, immsel=IMM_L, asel=ALUA_REG, bsel=ALUB_REG, alusel=ADD, pcsourse=PC_PLUS4.
- Reset (async, any state): state=FETCH, illegal=0, all enables 0. FETCH's own outputs assert only after rst deasserts. Reset mid-instruction aborts it with no RF/memory write.
- Opcodes: OP=0110011, OPIMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111.
- FETCH: irwrite=1, pccen=1, pcwrite=1, pcsourse=PC_PLUS4 -> DECODE.
- DECODE (A/B load rs1/rs2):
  - asel=PCC, bsel=IMM, immsel = IMM_J for JAL, else IMM_B; ALUOUT ends as target.
  - Next state by opcode: OP->EX_R; OPIMM->EX_I; LOAD/STORE->EX_ADDR; BRANCH->BR; JAL->JMP; JALR->EX_JR.
  - funct3=010/011 on BRANCH -> HALT. OPIMM funct3=101 with instr[30]=1 (SRAI) -> HALT. Other opcodes -> HALT.
- EX_R: bsel=REG, alusel={instr[30],funct3} -> WB_ALU.
- EX_I: bsel=IMM, immsel=IMM_L, alusel={1'b0,funct3} -> WB_ALU.
- WB_ALU: wbsel=ALUOUT, regwen=1, instr_done=1 -> FETCH.
- EX_ADDR: bsel=IMM, immsel = IMM_S for STORE, else IMM_L; ADD. LOAD->MEM_RD, STORE->MEM_WR.
- MEM_RD: addrsel=ALUOUT1, mdrwrite=1; keep EX_ADDR ALU controls -> WB_MEM.
- WB_MEM: wbsel=MDR, regwen=1, instr_done=1 -> FETCH.
- MEM_WR: addrsel=ALUOUT1, datawsel=REGB, dmem_wen=1, instr_done=1 -> FETCH.
- BR: bsel=REG, pcsourse=PC_ALU, instr_done=1 -> FETCH.
  - alusel: funct3[2]=0 -> SUB; 10x -> SLT; 11x -> SLTU.
  - pcwrite = zero XOR (funct3[0] XOR funct3[2]). Old ALUOUT (target) loads PC.
- JMP: pcwrite=1, pcsourse=PC_ALU, regwen=1, wbsel=WB_PC, instr_done=1 -> FETCH. Link = PC+4, pre-update.
- EX_JR: bsel=IMM, immsel=IMM_L, ADD -> JR.
- JR: same outputs as JMP. Target LSB is not cleared.
- HALT: all enables 0, illegal=1; held until rst.
- Writes to rd=x0 are issued normally; the datapath discards them.
- CPI: ALU 4, LW 5, SW 4, branch 3, JAL 3, JALR 4.

Decomposition:
- Package rv_pkg: state enum, opcode constants, all select encodings above (replaces the datapath's include constants).
- Sub-module rv_alu_dec: combinational alusel from opcode class, funct3 and instr[30].

Test Plan:
- `add x3,x1,x2` (0x002081B3) after reset -> FETCH, DECODE, EX_R(alusel=0000), WB_ALU(regwen=1, wbsel=1); instr_done at cycle 4.
- `lw x5,8(x1)` -> EX_ADDR immsel=IMM_L; MEM_RD mdrwrite=1; WB_MEM wbsel=0, regwen=1; 5 cycles.
- `sw x2,4(x1)` -> MEM_WR dmem_wen=1 exactly one cycle, datawsel=0, regwen never 1.
- `beq` with zero=1 -> pcwrite=1, pcsourse=1 in BR; zero=0 -> pcwrite=0. `bge` with zero=1 -> taken, alusel=0010.
- `jal x1,+16` -> DECODE immsel=IMM_J; JMP pcwrite=1, regwen=1, wbsel=2; 3 cycles.
- Opcode 0110111 (LUI) -> HALT, illegal=1 held. rst pulse mid-MEM_RD -> FETCH, illegal=0, no regwen.
